// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS writeback stage and register file.
package mips_pkg;

    localparam logic [4:0]  REG_ZERO           = 5'd0;
    localparam logic [31:0] FILL_VALUE_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 architectural register file: one synchronous write port, two
// combinational read ports with same-cycle write bypass and $0 forced to zero.
module regfile_2r1w
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);

    logic [31:0] r_regs [32];
    logic        w_we_eff;

    // $0 is never stored, so the bypass and the array both ignore it.
    assign w_we_eff = i_we && (i_waddr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_we_eff) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (i_raddr_a == REG_ZERO) begin
            o_rdata_a = 32'd0;
        end else if (w_we_eff && (i_raddr_a == i_waddr)) begin
            o_rdata_a = i_wdata;
        end
    end

    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (i_raddr_b == REG_ZERO) begin
            o_rdata_b = 32'd0;
        end else if (w_we_eff && (i_raddr_b == i_waddr)) begin
            o_rdata_b = i_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, load-wait FSM with timeout, register file
// commit, retire reporting and retired-instruction counter.
//
//   state | meaning
//   IDLE  | no load outstanding; commits ALU results and same-cycle loads
//   WAIT  | load data outstanding; pipeline frozen until valid or timeout
module wb_regfile
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FILL_VALUE     = FILL_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  write_reg_wb,
    input  logic [31:0] pc_wb,
    input  logic [31:0] alu_result_wb,
    input  logic        MemtoReg_wb,
    input  logic        DataC_wb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_stall,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic [31:0] instret,
    output logic        mem_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    wb_state_t        r_state;
    wb_state_t        w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             w_write;
    logic             w_commit;
    logic [31:0]      w_wdata;
    logic             w_stall;
    logic             w_timeout_set;
    logic             r_retire_valid;
    logic [31:0]      r_retire_pc;
    logic [31:0]      r_instret;
    logic             r_mem_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_write         = 1'b0;
        w_wdata         = alu_result_wb;
        w_stall         = 1'b0;
        w_timeout_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (DataC_wb) begin
                    if (!MemtoReg_wb) begin
                        w_write = 1'b1;
                        w_wdata = alu_result_wb;
                    end else if (mem_rdata_valid) begin
                        w_write = 1'b1;
                        w_wdata = mem_rdata;
                    end else begin
                        w_stall         = 1'b1;
                        w_state_next    = WAIT;
                        w_wait_cnt_next = CNT_ONE;
                    end
                end
            end
            WAIT: begin
                if (mem_rdata_valid) begin
                    w_write         = 1'b1;
                    w_wdata         = mem_rdata;
                    w_state_next    = IDLE;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == TIMEOUT_CNT) begin
                    // Give up on the load: poison the destination and flag it.
                    w_write         = 1'b1;
                    w_wdata         = FILL_VALUE;
                    w_timeout_set   = 1'b1;
                    w_state_next    = IDLE;
                    w_wait_cnt_next = '0;
                end else begin
                    w_stall         = 1'b1;
                    w_wait_cnt_next = r_wait_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // A reset cycle never commits, so late load data cannot leak through.
    assign w_commit = w_write && !rst;

    regfile_2r1w u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_commit),
        .i_waddr   (write_reg_wb),
        .i_wdata   (w_wdata),
        .i_raddr_a (rs_addr),
        .i_raddr_b (rt_addr),
        .o_rdata_a (rs_data),
        .o_rdata_b (rt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_valid <= 1'b0;
            r_retire_pc    <= 32'd0;
            r_instret      <= 32'd0;
            r_mem_timeout  <= 1'b0;
        end else begin
            r_retire_valid <= w_commit;
            if (w_commit) begin
                r_retire_pc <= pc_wb;
                r_instret   <= r_instret + 32'd1;
            end
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign wb_stall     = w_stall;
    assign retire_valid = r_retire_valid;
    assign retire_pc    = r_retire_pc;
    assign instret      = r_instret;
    assign mem_timeout  = r_mem_timeout;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined MIPS core. It consumes the MEM→WB pipeline register outputs and selects ALU result or load data. It commits the result into a 32×32 register file and serves the ID stage's two read ports with same-cycle write bypass. It stalls the pipeline while load data from a variable-latency data memory is outstanding, and counts retired instructions.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait for load data before the error path.
- FILL_VALUE, 32'hDEAD_BEEF: value written to the destination register on load timeout.

Ports:
- Clock/reset: single clock; reset is synchronous and active-high.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- write_reg_wb  in  5  destination register from MEM→WB.
- pc_wb  in  32  PC of the instruction in WB.
- alu_result_wb  in  32  ALU result from MEM→WB.
- MemtoReg_wb  in  1  1 = write load data, 0 = write ALU result.
- DataC_wb  in  1  instruction commits a register write this cycle (valid qualifier).
- mem_rdata  in  32  load data from data memory.
- mem_rdata_valid  in  1  mem_rdata is valid this cycle.
- rs_addr, rt_addr  in  5 each  ID-stage read addresses.
- rs_data, rt_data  out  32 each  read data (combinational, bypassed).
- wb_stall  out  1  freeze all upstream pipeline registers including MEM→WB.
- retire_valid  out  1  registered pulse, one cycle after a commit.
- retire_pc  out  32  registered PC of the retired instruction.
- instret  out  32  retired-instruction counter.
- mem_timeout  out  1  sticky load-timeout error.

## Operation
- State machine: IDLE, WAIT.
- IDLE, DataC_wb=0: no write, no stall.
- IDLE, DataC_wb=1, MemtoReg_wb=0: write alu_result_wb to write_reg_wb at the edge.
- IDLE, DataC_wb=1, MemtoReg_wb=1, mem_rdata_valid=1: write mem_rdata at the edge; no stall.
- IDLE, DataC_wb=1, MemtoReg_wb=1, mem_rdata_valid=0: wb_stall=1 combinationally; go to WAIT; wait counter ← 1.
- WAIT: wb_stall=1 while mem_rdata_valid=0. Upstream holds the MEM→WB inputs stable.
- WAIT, mem_rdata_valid=1: write mem_rdata; wb_stall=0 that cycle; go to IDLE.
- WAIT, wait counter reaches TIMEOUT_CYCLES with no valid: write FILL_VALUE; set mem_timeout; go to IDLE; wb_stall=0 that cycle.
- Register $0: writes are discarded; reads always return 0.
- Bypass: if a write occurs this cycle to a nonzero register and a read address matches it, the read port returns the write data.
- Commit (any actual write attempt, including to $0): instret += 1 (wraps at 2^32); retire_valid=1 and retire_pc=pc_wb on the next cycle.
- mem_rdata_valid while not waiting and not in a load commit is ignored.

## Timing
- Register write takes effect at the posedge of the commit cycle. A read in the following cycle sees the new value without the bypass.
- Load latency 0 (valid in the same cycle): no stall. Latency N≥1: wb_stall high for exactly N cycles.
- Timeout: wb_stall high for TIMEOUT_CYCLES cycles, then the FILL_VALUE write occurs on the next edge with stall low.
- Reset values: all 32 registers 0; state IDLE; wait counter 0; wb_stall 0; retire_valid 0; retire_pc 0; instret 0; mem_timeout 0.
- rst asserted in WAIT: return to IDLE, no write, stall drops after the reset edge.
- mem_timeout clears only on rst.

## Structure
- mips_pkg holds:
  - REG_ZERO (5'd0)
  - wb_state_t enum {IDLE, WAIT}
  - default FILL_VALUE constant
- Sub-module regfile_2r1w holds the storage: 32×32 array, one synchronous write port, two combinational read ports with write bypass and $0 forcing.
- wb_regfile holds the data mux, FSM, counters and retire register.

## Test plan
- ALU writeback: DataC=1, MemtoReg=0, write_reg=5, alu=0x1234 → next cycle rs_addr=5 reads 0x1234; instret=1; retire_pc=pc_wb.
- Bypass and $0: write 0xAAAA to r7 with rs_addr=7 in the same cycle → rs_data=0xAAAA immediately. Write 0xFFFF to r0 → r0 reads 0.
- Load latency 3: MemtoReg=1, valid arrives 3 cycles later with 0xCAFE → wb_stall high for exactly 3 cycles; r(dest)=0xCAFE; exactly one retire_valid pulse.
- Load with same-cycle valid: no stall; data committed at that edge.
- Timeout with TIMEOUT_CYCLES=4 and no valid → stall for 4 cycles; dest=0xDEADBEEF; mem_timeout=1 and stays 1 until rst.
- Reset mid-WAIT: rst in the 2nd wait cycle → registers 0, wb_stall 0, instret 0, no write of late data.
